// File: rtl/mem_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_arbiter_if
// Brief    : CPU, loader and memory handshake bundle for mem_access_arbiter.
// Revision : 1.0
// ============================================================================
interface mem_access_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_stall;
    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic [DATA_W-1:0] ldr_rdata;
    logic              ldr_ack;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        output ldr_rdata, ldr_ack,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requester / memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        input  ldr_rdata, ldr_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_arbiter
// Brief    : Shares one unified memory between the CPU controller and the
//            program loader; IDLE -> ACCESS (MEM_LAT cycles) -> RESP.
//            Define ARB_RR_EN for round-robin arbitration instead of loader
//            priority with a burst cap.
// Revision : 1.0
// ============================================================================
module mem_access_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MEM_LAT       = 2,
    parameter int LDR_MAX_BURST = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_access_arbiter_if.slave   bus
);

    localparam int             CNT_W      = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic                id_ldr_q, id_ldr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   ldr_rdata_q, ldr_rdata_d;
    logic                grant_ldr;

`ifdef ARB_RR_EN
    logic last_ldr_q, last_ldr_d;

    // Contended grant alternates; reset value favours the CPU first.
    always_comb begin
        grant_ldr = bus.ldr_req && !(bus.cpu_req && last_ldr_q);
    end
`else
    localparam int BURST_W = $clog2(LDR_MAX_BURST + 1);
    logic [BURST_W-1:0] burst_q, burst_d;

    always_comb begin
        grant_ldr = bus.ldr_req &&
                    !(bus.cpu_req && (burst_q == BURST_W'(LDR_MAX_BURST)));
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        id_ldr_d    = id_ldr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
`ifdef ARB_RR_EN
        last_ldr_d  = last_ldr_q;
`else
        burst_d     = burst_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.cpu_req || bus.ldr_req) begin
                    state_d  = S_ACCESS;
                    cnt_d    = C_CNT_LOAD;
                    id_ldr_d = grant_ldr;
                    we_d     = grant_ldr ? bus.ldr_we    : bus.cpu_we;
                    addr_d   = grant_ldr ? bus.ldr_addr  : bus.cpu_addr;
                    wdata_d  = grant_ldr ? bus.ldr_wdata : bus.cpu_wdata;
`ifdef ARB_RR_EN
                    last_ldr_d = grant_ldr;
`else
                    burst_d = (grant_ldr && bus.cpu_req) ? burst_q + 1'b1 : '0;
`endif
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    if (!we_q) begin
                        if (id_ldr_q) ldr_rdata_d = bus.mem_rdata;
                        else          cpu_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            id_ldr_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
`ifdef ARB_RR_EN
            last_ldr_q  <= 1'b1;
`else
            burst_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            id_ldr_q    <= id_ldr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
`ifdef ARB_RR_EN
            last_ldr_q  <= last_ldr_d;
`else
            burst_q     <= burst_d;
`endif
        end
    end

    // Decoded from the state register so reset drops enables immediately.
    assign bus.mem_en    = (state_q == S_ACCESS);
    assign bus.mem_we    = (state_q == S_ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_ack   = (state_q == S_RESP) && !id_ldr_q;
    assign bus.ldr_ack   = (state_q == S_RESP) &&  id_ldr_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.ldr_rdata = ldr_rdata_q;
    assign bus.cpu_stall = bus.cpu_req && !bus.cpu_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_arbiter
// Brief    : Self-checking bench: vector table, corner sequences and a
//            randomized run against a transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_mem_access_arbiter;

    localparam int MEM_LAT       = 2;
    localparam int LDR_MAX_BURST = 4;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    mem_access_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_access_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .LDR_MAX_BURST(LDR_MAX_BURST)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          ldr;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        logic [31:0] exp_cpu;
        logic [31:0] exp_ldr;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
        bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reference model state (transaction level)
    int          g, free_at, burst;
    bit          last_ldr, m_ldr, m_we;
    logic [31:0] m_addr, m_wdata, e_cpu_rd, e_ldr_rd;
    bit          cpu_pend, ldr_pend;
    logic        exp_ord[10];

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        clear_inputs();
        #1;
        chk("reset_mem_en",    bus.mem_en,    0);
        chk("reset_mem_we",    bus.mem_we,    0);
        chk("reset_cpu_ack",   bus.cpu_ack,   0);
        chk("reset_ldr_ack",   bus.ldr_ack,   0);
        chk("reset_mem_addr",  bus.mem_addr,  0);
        chk("reset_mem_wdata", bus.mem_wdata, 0);
        chk("reset_cpu_rdata", bus.cpu_rdata, 0);
        chk("reset_ldr_rdata", bus.ldr_rdata, 0);
        tick();
        reset = 1'b0;

        // ---------------- table-driven single transactions -----------------
        vt[0] = '{0, 0, 32'h10,       32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        vt[1] = '{1, 1, 32'h04,       32'h12345678, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h0};
        vt[2] = '{1, 0, 32'h20,       32'h0,        32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5};
        vt[3] = '{0, 1, 32'h30,       32'hCAFEF00D, 32'h11111111, 32'hDEADBEEF, 32'hA5A5A5A5};
        vt[4] = '{0, 0, 32'hFFFFFFFC, 32'h0,        32'h00000000, 32'h0,        32'hA5A5A5A5};
        vt[5] = '{1, 1, 32'h08,       32'h0BADF00D, 32'h22222222, 32'h0,        32'hA5A5A5A5};

        for (int i = 0; i < 6; i++) begin
            if (vt[i].ldr) begin
                bus.ldr_req = 1; bus.ldr_we = vt[i].we;
                bus.ldr_addr = vt[i].addr; bus.ldr_wdata = vt[i].wdata;
            end else begin
                bus.cpu_req = 1; bus.cpu_we = vt[i].we;
                bus.cpu_addr = vt[i].addr; bus.cpu_wdata = vt[i].wdata;
            end
            bus.mem_rdata = vt[i].mrd;
            #1;
            chk("vec_stall_c0", bus.cpu_stall, !vt[i].ldr);
            tick();
            chk("vec_mem_en_c1",    bus.mem_en,    1);
            chk("vec_mem_we_c1",    bus.mem_we,    vt[i].we);
            chk("vec_mem_addr_c1",  bus.mem_addr,  vt[i].addr);
            chk("vec_mem_wdata_c1", bus.mem_wdata, vt[i].wdata);
            chk("vec_ack_c1", {bus.cpu_ack, bus.ldr_ack}, 0);
            tick();
            chk("vec_mem_en_c2", bus.mem_en, 1);
            chk("vec_mem_we_c2", bus.mem_we, vt[i].we);
            tick();
            chk("vec_cpu_ack_c3", bus.cpu_ack,   !vt[i].ldr);
            chk("vec_ldr_ack_c3", bus.ldr_ack,    vt[i].ldr);
            chk("vec_mem_en_c3",  bus.mem_en,    0);
            chk("vec_cpu_rdata",  bus.cpu_rdata, vt[i].exp_cpu);
            chk("vec_ldr_rdata",  bus.ldr_rdata, vt[i].exp_ldr);
            chk("vec_stall_c3",   bus.cpu_stall, 0);
            bus.cpu_req = 0;
            bus.ldr_req = 0;
            tick();
            chk("vec_ack_c4", {bus.cpu_ack, bus.ldr_ack}, 0);
        end

        // ---------------- contended grant order ----------------------------
`ifdef ARB_RR_EN
        for (int k = 0; k < 10; k++) exp_ord[k] = (k % 2 == 1);
`else
        for (int k = 0; k < 10; k++) exp_ord[k] = !((k % 5) == 4);
`endif
        do_reset();
        bus.cpu_req = 1; bus.cpu_addr = 32'h100;
        bus.ldr_req = 1; bus.ldr_addr = 32'h200;
        begin
            int  c;
            bit  found;
            c = 0;
            for (int k = 0; k < 10; k++) begin
                found = 0;
                for (int w = 0; w < 8; w++) begin
                    tick();
                    c++;
                    if (bus.cpu_ack || bus.ldr_ack) begin
                        found = 1;
                        break;
                    end
                end
                if (!found) begin
                    chk("order_timeout", 0, 1);
                    break;
                end
                chk("grant_order", bus.ldr_ack, exp_ord[k]);
                chk("grant_ack_cycle", c, 4 * k + 3);
            end
        end
        clear_inputs();
        tick();

        // ---------------- reset in first ACCESS cycle ----------------------
        do_reset();
        bus.ldr_req = 1; bus.ldr_addr = 32'h44; bus.mem_rdata = 32'h77777777;
        tick();
        chk("rst_pre_mem_en", bus.mem_en, 1);
        reset = 1'b1;
        #1;
        chk("rst_mem_en_now", bus.mem_en, 0);
        chk("rst_ldr_ack",    bus.ldr_ack, 0);
        bus.ldr_req = 0;
        tick();
        reset = 1'b0;
        for (int w = 0; w < 5; w++) begin
            tick();
            chk("rst_no_ack",    {bus.cpu_ack, bus.ldr_ack, bus.mem_en}, 0);
        end
        chk("rst_ldr_rdata", bus.ldr_rdata, 0);
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h50; bus.mem_rdata = 32'h5555AAAA;
        tick(); tick(); tick();
        chk("post_rst_cpu_ack",   bus.cpu_ack,   1);
        chk("post_rst_cpu_rdata", bus.cpu_rdata, 32'h5555AAAA);
        bus.cpu_req = 0;
        tick();

        // ---------------- cpu_req dropped mid-access -----------------------
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h60; bus.mem_rdata = 32'h13572468;
        tick();
        bus.cpu_req = 0;
        tick();
        tick();
        chk("drop_cpu_ack",   bus.cpu_ack,   1);
        chk("drop_cpu_rdata", bus.cpu_rdata, 32'h13572468);
        for (int w = 0; w < 4; w++) begin
            tick();
            chk("drop_no_regrant", {bus.cpu_ack, bus.mem_en}, 0);
        end

        // ---------------- randomized run vs reference model ----------------
        do_reset();
        g = -1; free_at = 0; burst = 0; last_ldr = 1;
        m_ldr = 0; m_we = 0; m_addr = '0; m_wdata = '0;
        e_cpu_rd = '0; e_ldr_rd = '0; cpu_pend = 0; ldr_pend = 0;
        for (int c = 0; c < 1500; c++) begin
            bit e_en, e_cack, e_lack;
            e_en   = (g >= 0) && (c >= g + 1) && (c <= g + MEM_LAT);
            e_cack = (g >= 0) && (c == g + MEM_LAT + 1) && !m_ldr;
            e_lack = (g >= 0) && (c == g + MEM_LAT + 1) &&  m_ldr;
            chk("rnd_mem_en",    bus.mem_en,    e_en);
            chk("rnd_cpu_ack",   bus.cpu_ack,   e_cack);
            chk("rnd_ldr_ack",   bus.ldr_ack,   e_lack);
            chk("rnd_cpu_rdata", bus.cpu_rdata, e_cpu_rd);
            chk("rnd_ldr_rdata", bus.ldr_rdata, e_ldr_rd);
            chk("rnd_cpu_stall", bus.cpu_stall, bus.cpu_req && !e_cack);
            if (e_en) begin
                chk("rnd_mem_we",   bus.mem_we,   m_we);
                chk("rnd_mem_addr", bus.mem_addr, m_addr);
                if (m_we) chk("rnd_mem_wdata", bus.mem_wdata, m_wdata);
            end
            if (e_cack) cpu_pend = 0;
            if (e_lack) ldr_pend = 0;
            if (!cpu_pend && !e_cack && ($urandom_range(0, 2) == 0)) begin
                cpu_pend = 1;
                bus.cpu_we = $urandom_range(0, 1); bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom;
            end
            if (!ldr_pend && !e_lack && ($urandom_range(0, 1) == 0)) begin
                ldr_pend = 1;
                bus.ldr_we = $urandom_range(0, 1); bus.ldr_addr = $urandom; bus.ldr_wdata = $urandom;
            end
            bus.cpu_req = cpu_pend;
            bus.ldr_req = ldr_pend;
            bus.mem_rdata = $urandom;
            if ((g >= 0) && (c == g + MEM_LAT) && !m_we) begin
                if (m_ldr) e_ldr_rd = bus.mem_rdata;
                else       e_cpu_rd = bus.mem_rdata;
            end
            if ((c >= free_at) && (cpu_pend || ldr_pend)) begin
`ifdef ARB_RR_EN
                m_ldr    = (cpu_pend && ldr_pend) ? !last_ldr : ldr_pend;
                last_ldr = m_ldr;
`else
                if (cpu_pend && ldr_pend && burst == LDR_MAX_BURST) begin
                    m_ldr = 0; burst = 0;
                end else if (ldr_pend) begin
                    m_ldr = 1; burst = cpu_pend ? burst + 1 : 0;
                end else begin
                    m_ldr = 0; burst = 0;
                end
`endif
                m_we    = m_ldr ? bus.ldr_we    : bus.cpu_we;
                m_addr  = m_ldr ? bus.ldr_addr  : bus.cpu_addr;
                m_wdata = m_ldr ? bus.ldr_wdata : bus.cpu_wdata;
                g       = c;
                free_at = c + MEM_LAT + 2;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
